// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC sequencer: sel code layout and default vector addresses.
package pc_seq_pkg;

  // Codes 0..N_TGT-1 select targets; the remaining codes are offsets above N_TGT.
  localparam int TGT_BASE = 0;
  localparam int VEC_BASE = 0;
  localparam int CALL_OFS = 3;
  localparam int RET_OFS  = 4;

  localparam int VEC0_DEFAULT = 22;
  localparam int VEC1_DEFAULT = 12;
  localparam int VEC2_DEFAULT = 200;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack with saturating count; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  // Next pointer and count; the pointer wraps naturally because DEPTH is a power of two.
  always_comb begin
    do_push_s = push;
    do_pop_s  = pop && !push && (cnt_q != CW'(0));
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (do_push_s) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (do_pop_s) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[ptr_q] <= push_data;
    end
  end

  assign top   = mem_q[ptr_q - PW'(1)];
  assign empty = (cnt_q == CW'(0));
  assign full  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with target/vector redirect, call/return stack and stall-deferred redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 17,
  parameter int              N_TGT     = 4,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] VEC0      = PC_W'(VEC0_DEFAULT),
  parameter logic [PC_W-1:0] VEC1      = PC_W'(VEC1_DEFAULT),
  parameter logic [PC_W-1:0] VEC2      = PC_W'(VEC2_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [3:0]              sel,
  input  logic [N_TGT*PC_W-1:0]   targets,
  output logic [PC_W-1:0]         pc,
  output logic [PC_W-1:0]         pc_next,
  output logic                    redirect_pending,
  output logic                    ras_empty,
  output logic                    ras_full,
  output logic                    sel_err
);

  localparam int SEL_VEC  = N_TGT + VEC_BASE;
  localparam int SEL_CALL = N_TGT + CALL_OFS;
  localparam int SEL_RET  = N_TGT + RET_OFS;

  logic [PC_W-1:0] pc_q, pc_d, ptgt_q, ptgt_d;
  logic            pend_q, pend_d, sel_err_q, sel_err_d;
  logic [PC_W-1:0] pc_inc_s, tgt_s, resolved_s, ras_top_s;
  logic            push_s, pop_s, err_s;

  assign pc_inc_s = pc_q + PC_W'(1);

  // Pick targets[sel] using constant part-selects only.
  always_comb begin
    tgt_s = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (int'(sel) == TGT_BASE + i) begin
        tgt_s = targets[i*PC_W +: PC_W];
      end else begin
        tgt_s = tgt_s;
      end
    end
  end

  // Resolve the redirect target and the stack operation it implies.
  always_comb begin
    resolved_s = pc_inc_s;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    err_s      = 1'b0;
    if (!redirect_valid) begin
      resolved_s = pc_inc_s;
    end else if (int'(sel) < TGT_BASE + N_TGT) begin
      resolved_s = tgt_s;
    end else if (int'(sel) == SEL_VEC) begin
      resolved_s = VEC0;
    end else if (int'(sel) == SEL_VEC + 1) begin
      resolved_s = VEC1;
    end else if (int'(sel) == SEL_VEC + 2) begin
      resolved_s = VEC2;
    end else if (int'(sel) == SEL_CALL) begin
      resolved_s = targets[PC_W-1:0];
      push_s     = 1'b1;
    end else if (int'(sel) == SEL_RET) begin
      if (ras_empty) begin
        err_s = 1'b1;
      end else begin
        resolved_s = ras_top_s;
        pop_s      = 1'b1;
      end
    end else begin
      err_s = 1'b1;
    end
  end

  // A stalled redirect is parked as pending (newest wins) and released on the first unstalled edge.
  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    ptgt_d    = ptgt_q;
    sel_err_d = err_s;
    if (!stall) begin
      if (redirect_valid) begin
        pc_d = resolved_s;
      end else if (pend_q) begin
        pc_d = ptgt_q;
      end else begin
        pc_d = pc_inc_s;
      end
      pend_d = 1'b0;
    end else begin
      pc_d = pc_q;
      if (redirect_valid) begin
        pend_d = 1'b1;
        ptgt_d = resolved_s;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  // Sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      ptgt_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      ptgt_q    <= ptgt_d;
      sel_err_q <= sel_err_d;
    end
  end

  return_stack #(
    .WIDTH (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top       (ras_top_s),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc               = pc_q;
  assign pc_next          = pc_d;
  assign redirect_pending = pend_q;
  assign sel_err          = sel_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [67:0] targets = 68'd0;
  logic [16:0] pc, pc_next;
  logic        redirect_pending, ras_empty, ras_full, sel_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [16:0] m_tgt [4];
  logic [16:0] m_pc;
  logic        m_pend;
  logic [16:0] m_ptgt;
  logic        m_err;
  logic [16:0] m_ras [$];

  pc_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .sel              (sel),
    .targets          (targets),
    .pc               (pc),
    .pc_next          (pc_next),
    .redirect_pending (redirect_pending),
    .ras_empty        (ras_empty),
    .ras_full         (ras_full),
    .sel_err          (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 17'd0;
    m_pend = 1'b0;
    m_ptgt = 17'd0;
    m_err  = 1'b0;
    m_ras.delete();
  endtask

  task automatic check_state();
    chk("pc", {15'd0, pc}, {15'd0, m_pc});
    chk("pending", {31'd0, redirect_pending}, {31'd0, m_pend});
    chk("ras_empty", {31'd0, ras_empty}, {31'd0, (m_ras.size() == 0)});
    chk("ras_full", {31'd0, ras_full}, {31'd0, (m_ras.size() == 4)});
    chk("sel_err", {31'd0, sel_err}, {31'd0, m_err});
  endtask

  // One clock: drive inputs, predict pc_next, clock, then compare the registered state.
  task automatic step(input logic st, input logic rv, input logic [3:0] s);
    logic [16:0] inc, tgt, nxt;
    logic err, push, pop;
    stall = st; redirect_valid = rv; sel = s;
    for (int i = 0; i < 4; i++) targets[i*17 +: 17] = m_tgt[i];
    inc = m_pc + 17'd1;
    tgt = inc; err = 1'b0; push = 1'b0; pop = 1'b0;
    if (!rv) tgt = inc;
    else if (s < 4'd4) tgt = m_tgt[s[1:0]];
    else if (s == 4'd4) tgt = 17'd22;
    else if (s == 4'd5) tgt = 17'd12;
    else if (s == 4'd6) tgt = 17'd200;
    else if (s == 4'd7) begin tgt = m_tgt[0]; push = 1'b1; end
    else if (s == 4'd8) begin
      if (m_ras.size() == 0) err = 1'b1;
      else begin tgt = m_ras[$]; pop = 1'b1; end
    end else err = 1'b1;
    nxt = st ? m_pc : (rv ? tgt : (m_pend ? m_ptgt : inc));
    #2;
    chk("pc_next", {15'd0, pc_next}, {15'd0, nxt});
    @(posedge clk);
    if (push) begin
      m_ras.push_back(inc);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    if (pop) void'(m_ras.pop_back());
    if (!st) begin m_pc = nxt; m_pend = 1'b0; end
    else if (rv) begin m_pend = 1'b1; m_ptgt = tgt; end
    m_err = err;
    #1;
    check_state();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_tgt[i] = 17'd0;
    model_reset();
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 4'd0);
    chk("free_run_pc3", {15'd0, pc}, 32'd3);

    // Vectors and plain target
    step(1'b0, 1'b1, 4'd4); chk("vec0", {15'd0, pc}, 32'd22);
    step(1'b0, 1'b1, 4'd5); chk("vec1", {15'd0, pc}, 32'd12);
    step(1'b0, 1'b1, 4'd6); chk("vec2", {15'd0, pc}, 32'd200);
    m_tgt[2] = 17'h155;
    step(1'b0, 1'b1, 4'd2); chk("tgt2", {15'd0, pc}, 32'h155);

    // Call / return / return-on-empty
    m_tgt[0] = 17'd10; step(1'b0, 1'b1, 4'd0);
    m_tgt[0] = 17'd40; step(1'b0, 1'b1, 4'd7); chk("call", {15'd0, pc}, 32'd40);
    step(1'b0, 1'b1, 4'd8); chk("ret", {15'd0, pc}, 32'd11);
    step(1'b0, 1'b1, 4'd8); chk("ret_empty_pc", {15'd0, pc}, 32'd12);
    chk("ret_empty_err", {31'd0, sel_err}, 32'd1);
    step(1'b0, 1'b0, 4'd0); chk("err_one_cycle", {31'd0, sel_err}, 32'd0);

    // Stall with two redirects, newest wins
    m_tgt[0] = 17'd100; m_tgt[1] = 17'd200;
    step(1'b1, 1'b1, 4'd0);
    step(1'b1, 1'b1, 4'd1);
    step(1'b1, 1'b0, 4'd0);
    chk("stall_hold", {15'd0, pc}, 32'd13);
    chk("stall_pending", {31'd0, redirect_pending}, 32'd1);
    step(1'b0, 1'b0, 4'd0);
    chk("stall_release", {15'd0, pc}, 32'd200);

    // Five calls overflow a four-deep stack, four returns in LIFO order
    for (int k = 0; k < 5; k++) begin
      m_tgt[0] = 17'(1000 + 16 * k);
      step(1'b0, 1'b1, 4'd7);
    end
    chk("ras_full", {31'd0, ras_full}, 32'd1);
    step(1'b0, 1'b1, 4'd8); chk("lifo0", {15'd0, pc}, 32'd1049);
    step(1'b0, 1'b1, 4'd8); chk("lifo1", {15'd0, pc}, 32'd1033);
    step(1'b0, 1'b1, 4'd8); chk("lifo2", {15'd0, pc}, 32'd1017);
    step(1'b0, 1'b1, 4'd8); chk("lifo3", {15'd0, pc}, 32'd1001);
    step(1'b0, 1'b1, 4'd8);

    // Wrap
    m_tgt[0] = 17'h1FFFF; step(1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'd0); chk("wrap", {15'd0, pc}, 32'd0);

    // Illegal code
    m_tgt[0] = 17'd7; step(1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 4'd15);
    chk("illegal_pc", {15'd0, pc}, 32'd8);
    chk("illegal_err", {31'd0, sel_err}, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < 4; i++) m_tgt[i] = 17'($urandom);
      end
      step(($urandom_range(9) < 3) ? 1'b1 : 1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    // Asynchronous reset mid-stream, then one free-run edge
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #2;
    step(1'b0, 1'b0, 4'd0);
    chk("post_reset_pc", {15'd0, pc}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the single-cycle CPU. It replaces the purely combinational branch-target select with a clocked PC register. The block supports a parametrised number of branch-target inputs, fixed vector addresses, stall with deferred redirect, and a small return-address stack (RAS) for call/return. It sits between the branch/decode logic, which supplies `sel` and targets, and instruction memory, which consumes `pc`.

## Interface
Parameters:
- `PC_W`, 17, PC and target width.
- `N_TGT`, 4, number of target inputs; legal range 1..11.
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥2.
- `RESET_PC`, 0, PC value after reset.
- `VEC0` / `VEC1` / `VEC2`, 22 / 12 / 200, fixed vector addresses.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `stall`, in, 1: hold PC this cycle.
- `redirect_valid`, in, 1: take the `sel` redirect this cycle; 0 means sequential.
- `sel`, in, 4: redirect source code.
- `targets`, in, N_TGT*PC_W: target i occupies bits [i*PC_W +: PC_W].
- `pc`, out, PC_W: current PC, registered.
- `pc_next`, out, PC_W: value `pc` takes at the next edge, combinational.
- `redirect_pending`, out, 1: a redirect captured during stall is waiting.
- `ras_empty`, out, 1: RAS holds no entries.
- `ras_full`, out, 1: RAS holds RAS_DEPTH entries.
- `sel_err`, out, 1: registered one-cycle pulse on an illegal `sel` or on RET with an empty RAS.

## Operation
- `sel` decode:
  - 0..N_TGT-1: `targets[sel]`.
  - N_TGT, N_TGT+1, N_TGT+2: VEC0, VEC1, VEC2.
  - N_TGT+3 (CALL): push pc+1, jump to `targets[0]`.
  - N_TGT+4 (RET): pop, jump to the popped value.
  - Any higher code is illegal.
- Resolved target when `redirect_valid`=0, on an illegal code, or on RET with the RAS empty: pc+1. The latter two also set `sel_err`, and no RAS change occurs.
- pc+1 is modulo 2^PC_W, so the maximum value wraps to 0.
- Not stalled (`stall`=0):
  - If `redirect_valid`=1, `pc` loads the resolved target. A new redirect overrides any pending one.
  - Otherwise, if `redirect_pending`=1, `pc` loads the pending target.
  - Otherwise `pc` loads pc+1.
  - `redirect_pending` clears.
- Stalled (`stall`=1):
  - `pc` holds.
  - If `redirect_valid`=1, the resolved target is latched as pending, `redirect_pending` sets, and the RAS op executes in that same cycle.
  - A later redirect during the same stall replaces the pending target, newest wins, and its RAS op also executes.
  - Sequential (`redirect_valid`=0) cycles during stall never alter a pending target.
- RAS behaviour:
  - Circular buffer with a count.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH and `ras_full` stays 1.
  - Pop returns the most recent entry.
  - Push and pop are mutually exclusive by encoding.
- Reset values (asynchronous, while `rst_n`=0):
  - `pc`=RESET_PC, `redirect_pending`=0, `sel_err`=0.
  - RAS count=0, so `ras_empty`=1 and `ras_full`=0.
  - Stored RAS data is don't-care.

## Timing
- Redirect latency is one edge: target presented in cycle n is on `pc` in cycle n+1.
- Pending release: `pc` takes the pending target on the first edge with `stall`=0.
- `pc_next` is combinational from `pc`, `stall`, `redirect_valid`, `sel`, `targets`, the pending state and RAS top. It equals `pc` while stalled.
- `sel_err` is high in the cycle after the offending edge, for exactly one cycle.
- `ras_empty` and `ras_full` are registered-state derived and reflect the count after the edge.
- Reset deasserted mid-stream: the first post-reset edge with `stall`=0 and `redirect_valid`=0 gives `pc`=RESET_PC+1.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the `sel` code offsets (TGT_BASE, VEC_BASE, CALL_OFS, RET_OFS);
  - default VEC0, VEC1, VEC2 constants.
- Sub-module `return_stack`:
  - parameters: width, depth;
  - ports: push, pop, push_data, top, empty, full;
  - same clock and reset.

## Test plan
- Reset: hold `rst_n`=0, then release with RESET_PC=0 → `pc`=0, `ras_empty`=1; after 3 free-run edges `pc`=3.
- Legacy compatibility: N_TGT=4, `redirect_valid`=1 with `sel`=4/5/6 → `pc`=22/12/200 next cycle; `sel`=2 with targets[2]=0x155 → `pc`=0x155.
- Call/return:
  - At `pc`=10, CALL with targets[0]=40 → `pc`=40 and RAS top=11.
  - RET → `pc`=11 and `ras_empty`=1.
  - A second RET → `pc`=12 and `sel_err` pulses once.
- Stall: `stall`=1 for 3 cycles, with redirect `sel`=0 (target 100) in cycle 1 and `sel`=1 (target 200) in cycle 2 → `pc` holds and `redirect_pending`=1; on release `pc`=200 and pending clears.
- Overflow and wrap:
  - 5 CALLs with RAS_DEPTH=4 → `ras_full`=1; 4 RETs return the last 4 return addresses in LIFO order.
  - `pc`=0x1FFFF sequential → `pc`=0.
- Illegal code: `sel`=15 with `redirect_valid`=1 at `pc`=7 → `pc`=8, `sel_err` pulses for 1 cycle, RAS unchanged.
